// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit in front of a word-only data memory.
// Sub-word stores use read-modify-write; loads are lane-extracted and extended.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses report rsp_misalign
// and skip memory; otherwise low address bits are force-aligned.
// Ports: clock/resetn; req_* CPU request (valid/ready); rsp_* one-cycle
// response; mem_* word-aligned strobes and data to the memory.
module lsu_rmw #(
    parameter int ADDR_W = 11
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_misalign,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RMW_RD,
        S_WR,
`ifdef LSU_MISALIGN_TRAP_EN
        S_ERR,
`endif
        S_RSP
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              write_q, write_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       merge_q, merge_d;
    logic [31:0]       rdata_q, rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic              mis_q, mis_d;
    logic              req_mis;
`endif

    logic [ADDR_W-1:0] acc_addr;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_ext;
    logic [31:0]       store_merge;

    // Size 3 is reserved and behaves as a word, so bit 1 alone marks a word.
    always_comb begin
        acc_addr = req_addr;
`ifndef LSU_MISALIGN_TRAP_EN
        if (req_size == 2'd1) begin
            acc_addr[0] = 1'b0;
        end
        if (req_size[1]) begin
            acc_addr[1:0] = 2'b00;
        end
`endif
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_mis = ((req_size == 2'd1) && req_addr[0])
                   || (req_size[1] && (req_addr[1:0] != 2'b00));
`endif

    // Little-endian lane selection from the latched byte offset.
    always_comb begin
        lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        load_ext = mem_rdata;
        if (size_q == 2'd0) begin
            load_ext = signed_q ? {{24{lane_b[7]}}, lane_b}
                                : {24'h0, lane_b};
        end else if (size_q == 2'd1) begin
            load_ext = signed_q ? {{16{lane_h[15]}}, lane_h}
                                : {16'h0, lane_h};
        end
    end

    // Overlay the store lane(s) onto the word just read.
    always_comb begin
        store_merge = mem_rdata;
        if (size_q == 2'd0) begin
            store_merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            store_merge[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d    = mis_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = acc_addr;
                    size_d   = req_size;
                    signed_d = req_signed;
                    write_d  = req_write;
                    wdata_d  = req_wdata;
                    merge_d  = 32'h0;
                    rdata_d  = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
                    mis_d    = 1'b0;
                    if (req_mis) begin
                        state_d = S_ERR;
                    end else
`endif
                    if (!req_write) begin
                        state_d = S_RD;
                    end else if (req_size[1]) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_RD: begin
                rdata_d = load_ext;
                state_d = S_RSP;
            end
            S_RMW_RD: begin
                merge_d = store_merge;
                state_d = S_WR;
            end
            S_WR: begin
                state_d = S_RSP;
            end
`ifdef LSU_MISALIGN_TRAP_EN
            S_ERR: begin
                mis_d   = 1'b1;
                state_d = S_RSP;
            end
`endif
            S_RSP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= 32'h0;
            merge_q  <= 32'h0;
            rdata_q  <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q    <= mis_d;
`endif
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RSP);
    assign rsp_rdata   = rdata_q;
    assign mem_read    = (state_q == S_RD) || (state_q == S_RMW_RD);
    assign mem_write   = (state_q == S_WR) && write_q;
    assign mem_address = (state_q == S_IDLE) ? '0
                                             : {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata   = (state_q != S_WR) ? 32'h0
                       : (size_q[1] ? wdata_q : merge_q);
`ifdef LSU_MISALIGN_TRAP_EN
    assign rsp_misalign = mis_q;
`else
    assign rsp_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_rmw.sv
// tb_lsu_rmw: directed bench for lsu_rmw with a word memory model
// that reads combinationally and writes on the falling clock edge.
module tb_lsu_rmw;

    logic        clock;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misalign;
    logic [10:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:511];
    logic        mem_clr;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [10:0] last_waddr = '0;

    lsu_rmw #(.ADDR_W(11)) dut (
        .clock(clock),
        .resetn(resetn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_size(req_size),
        .req_signed(req_signed),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_misalign(rsp_misalign),
        .mem_address(mem_address),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_address[10:2]];

    always @(negedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        end else if (mem_write) begin
            mem[mem_address[10:2]] = mem_wdata;
            wr_cnt++;
            last_waddr = mem_address;
        end
        if (mem_read) rd_cnt++;
    end

    // Issues one request from IDLE and waits (bounded) for its response.
    // cyc counts edges from the accept edge to rsp_valid (10 = timed out).
    task automatic do_req(
        input  logic        w,
        input  logic [1:0]  sz,
        input  logic        sg,
        input  logic [10:0] a,
        input  logic [31:0] wd,
        output logic [31:0] rd,
        output logic        mis,
        output int          cyc,
        output int          nrd,
        output int          nwr,
        output logic        extra
    );
        int rd0;
        int wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        req_valid = 1'b1;
        req_write = w;
        req_size = sz;
        req_signed = sg;
        req_addr = a;
        req_wdata = wd;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 10) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        rd = rsp_rdata;
        mis = rsp_misalign;
        @(posedge clock);
        #1;
        extra = rsp_valid;
        nrd = rd_cnt - rd0;
        nwr = wr_cnt - wr0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        mem_clr = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({rsp_valid, rsp_misalign, mem_read, mem_write} !== 4'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=0000",
                     {rsp_valid, rsp_misalign, mem_read, mem_write});
        end
        checks++;
        if (rsp_rdata !== 32'h0 || mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_data rdata=%h wdata=%h exp=0",
                     rsp_rdata, mem_wdata);
        end
        checks++;
        if (mem_address !== 11'h0) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=0", mem_address);
        end
        resetn = 1'b1;
        mem_clr = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", req_ready);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd;
        logic        mis;
        logic        ex;
        int          cyc;
        int          nrd;
        int          nwr;
        do_req(1'b1, 2'd2, 1'b0, 11'h010, 32'hDEADBEEF,
               rd, mis, cyc, nrd, nwr, ex);
        checks++;
        if (cyc !== 2) begin
            failures++;
            $display("FAIL sw_latency got=%0d exp=2", cyc);
        end
        checks++;
        if (nwr !== 1 || nrd !== 0) begin
            failures++;
            $display("FAIL sw_strobes wr=%0d rd=%0d exp=1/0", nwr, nrd);
        end
        checks++;
        if (last_waddr !== 11'h010) begin
            failures++;
            $display("FAIL sw_addr got=%h exp=010", last_waddr);
        end
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL sw_mem got=%h exp=deadbeef", mem[4]);
        end
        checks++;
        if (rd !== 32'h0 || ex !== 1'b0) begin
            failures++;
            $display("FAIL sw_rsp rdata=%h extra=%b exp=0/0", rd, ex);
        end
        do_req(1'b0, 2'd2, 1'b0, 11'h010, 32'h0,
               rd, mis, cyc, nrd, nwr, ex);
        checks++;
        if (rd !== 32'hDEADBEEF || cyc !== 2) begin
            failures++;
            $display("FAIL lw_data got=%h cyc=%0d exp=deadbeef/2", rd, cyc);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd;
        logic        mis;
        logic        ex;
        int          cyc;
        int          nrd;
        int          nwr;
        do_req(1'b1, 2'd2, 1'b0, 11'h010, 32'h11223344,
               rd, mis, cyc, nrd, nwr, ex);
        do_req(1'b1, 2'd0, 1'b0, 11'h011, 32'h000000AA,
               rd, mis, cyc, nrd, nwr, ex);
        checks++;
        if (cyc !== 3 || nrd !== 1 || nwr !== 1) begin
            failures++;
            $display("FAIL sb_timing cyc=%0d rd=%0d wr=%0d exp=3/1/1",
                     cyc, nrd, nwr);
        end
        checks++;
        if (mem[4] !== 32'h1122AA44) begin
            failures++;
            $display("FAIL sb_mem got=%h exp=1122aa44", mem[4]);
        end
        do_req(1'b0, 2'd0, 1'b1, 11'h011, 32'h0,
               rd, mis, cyc, nrd, nwr, ex);
        checks++;
        if (rd !== 32'hFFFFFFAA) begin
            failures++;
            $display("FAIL lb got=%h exp=ffffffaa", rd);
        end
        do_req(1'b0, 2'd0, 1'b0, 11'h011, 32'h0,
               rd, mis, cyc, nrd, nwr, ex);
        checks++;
        if (rd !== 32'h000000AA) begin
            failures++;
            $display("FAIL lbu got=%h exp=000000aa", rd);
        end
    endtask

    task automatic test_half();
        logic [31:0] rd;
        logic        mis;
        logic        ex;
        int          cyc;
        int          nrd;
        int          nwr;
        do_req(1'b1, 2'd2, 1'b0, 11'h010, 32'h11223344,
               rd, mis, cyc, nrd, nwr, ex);
        do_req(1'b1, 2'd1, 1'b0, 11'h012, 32'h00008001,
               rd, mis, cyc, nrd, nwr, ex);
        checks++;
        if (mem[4] !== 32'h80013344) begin
            failures++;
            $display("FAIL sh_mem got=%h exp=80013344", mem[4]);
        end
        do_req(1'b0, 2'd1, 1'b1, 11'h012, 32'h0,
               rd, mis, cyc, nrd, nwr, ex);
        checks++;
        if (rd !== 32'hFFFF8001) begin
            failures++;
            $display("FAIL lh got=%h exp=ffff8001", rd);
        end
        do_req(1'b0, 2'd1, 1'b0, 11'h012, 32'h0,
               rd, mis, cyc, nrd, nwr, ex);
        checks++;
        if (rd !== 32'h00008001) begin
            failures++;
            $display("FAIL lhu got=%h exp=00008001", rd);
        end
        do_req(1'b0, 2'd1, 1'b0, 11'h010, 32'h0,
               rd, mis, cyc, nrd, nwr, ex);
        checks++;
        if (rd !== 32'h00003344) begin
            failures++;
            $display("FAIL lhu_low got=%h exp=00003344", rd);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        logic        mis;
        logic        ex;
        int          cyc;
        int          nrd;
        int          nwr;
        do_req(1'b1, 2'd2, 1'b0, 11'h010, 32'hCAFEF00D,
               rd, mis, cyc, nrd, nwr, ex);
        do_req(1'b0, 2'd2, 1'b0, 11'h013, 32'h0,
               rd, mis, cyc, nrd, nwr, ex);
        checks++;
        if (cyc !== 2) begin
            failures++;
            $display("FAIL mis_latency got=%0d exp=2", cyc);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        checks++;
        if (mis !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL mis_trap mis=%b rdata=%h exp=1/0", mis, rd);
        end
        checks++;
        if (nrd !== 0 || nwr !== 0) begin
            failures++;
            $display("FAIL mis_nomem rd=%0d wr=%0d exp=0/0", nrd, nwr);
        end
`else
        checks++;
        if (mis !== 1'b0 || rd !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL mis_align mis=%b rdata=%h exp=0/cafef00d",
                     mis, rd);
        end
        do_req(1'b0, 2'd1, 1'b0, 11'h013, 32'h0,
               rd, mis, cyc, nrd, nwr, ex);
        checks++;
        if (rd !== 32'h0000CAFE) begin
            failures++;
            $display("FAIL mis_half got=%h exp=0000cafe", rd);
        end
`endif
    endtask

    task automatic test_reset_rmw();
        logic [31:0] rd;
        logic        mis;
        logic        ex;
        int          cyc;
        int          nrd;
        int          nwr;
        int          wr0;
        int          seen;
        do_req(1'b1, 2'd2, 1'b0, 11'h010, 32'h11223344,
               rd, mis, cyc, nrd, nwr, ex);
        wr0 = wr_cnt;
        seen = 0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size = 2'd0;
        req_signed = 1'b0;
        req_addr = 11'h011;
        req_wdata = 32'h000000AA;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        resetn = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid === 1'b1) seen++;
            @(posedge clock);
            #1;
        end
        checks++;
        if (wr_cnt - wr0 !== 0 || mem[4] !== 32'h11223344) begin
            failures++;
            $display("FAIL rst_rmw_mem wr=%0d mem=%h exp=0/11223344",
                     wr_cnt - wr0, mem[4]);
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL rst_rmw_rsp got=%0d exp=0", seen);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_rmw_ready got=%b exp=1", req_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        mis;
        logic        ex;
        int          cyc;
        int          nrd;
        int          nwr;
        logic [31:0] resp [0:3];
        int          nr;
        int          nacc;
        int          acc2;
        int          bad_rdy;
        logic        rdy_before;
        do_req(1'b1, 2'd2, 1'b0, 11'h010, 32'hAAAA0001,
               rd, mis, cyc, nrd, nwr, ex);
        do_req(1'b1, 2'd2, 1'b0, 11'h014, 32'hBBBB0002,
               rd, mis, cyc, nrd, nwr, ex);
        nr = 0;
        nacc = 0;
        acc2 = -1;
        bad_rdy = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size = 2'd2;
        req_signed = 1'b0;
        req_addr = 11'h010;
        for (int e = 0; e < 10; e++) begin
            rdy_before = req_ready;
            @(posedge clock);
            #1;
            if (rdy_before === 1'b1 && req_valid === 1'b1) begin
                nacc++;
                if (nacc == 1) begin
                    req_addr = 11'h014;
                end else begin
                    req_valid = 1'b0;
                    acc2 = e;
                end
            end
            if (rsp_valid === 1'b1) begin
                if (nr < 4) resp[nr] = rsp_rdata;
                nr++;
                if (req_ready !== 1'b0) bad_rdy++;
            end
            if (e == 0 && req_ready !== 1'b0) bad_rdy++;
        end
        req_valid = 1'b0;
        checks++;
        if (nacc !== 2 || acc2 !== 3) begin
            failures++;
            $display("FAIL b2b_accept n=%0d edge=%0d exp=2/3", nacc, acc2);
        end
        checks++;
        if (nr !== 2) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=2", nr);
        end else begin
            checks++;
            if (resp[0] !== 32'hAAAA0001 || resp[1] !== 32'hBBBB0002) begin
                failures++;
                $display("FAIL b2b_order got=%h,%h exp=aaaa0001,bbbb0002",
                         resp[0], resp[1]);
            end
        end
        checks++;
        if (bad_rdy !== 0) begin
            failures++;
            $display("FAIL b2b_ready_busy got=%0d exp=0", bad_rdy);
        end
    endtask

    initial begin
        resetn = 1'b0;
        mem_clr = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size = 2'd0;
        req_signed = 1'b0;
        req_addr = '0;
        req_wdata = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_reset_rmw();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit sitting directly upstream of the word-only data memory.
- Accepts byte, halfword and word loads/stores from the CPU datapath.
- Performs read-modify-write for sub-word stores, since the memory only writes full words.
- Sign/zero-extends load data and stalls the CPU through a ready/valid handshake while an access is in flight.

Parameters:
ADDR_W, 11, byte-address width; the word index is addr[ADDR_W-1:2]

Ports:
clock  input  1  system clock; all state updates on posedge
resetn  input  1  asynchronous active-low reset
req_valid  input  1  CPU presents a request
req_ready  output  1  unit can accept a request this cycle (high only in IDLE)
req_write  input  1  1=store, 0=load
req_size  input  2  0=byte, 1=half, 2=word; 3 reserved (treated as word)
req_signed  input  1  loads only: 1=sign-extend, 0=zero-extend
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-justified
rsp_valid  output  1  one-cycle pulse: access complete
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_misalign  output  1  qualified by rsp_valid; access was misaligned
mem_address  output  ADDR_W  word-aligned address to memory, low 2 bits always 0
mem_read  output  1  memory read enable
mem_write  output  1  memory write enable
mem_wdata  output  32  full word to write
mem_rdata  input  32  combinational read data from memory

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; all request/data registers are 0.
  - rsp_valid=0, rsp_misalign=0, rsp_rdata=0, mem_read=0, mem_write=0, mem_wdata=0, mem_address=0.
  - req_ready=1 once reset is released.
- Memory strobes and req_ready are decoded combinationally from registered state, so reset kills mem_write immediately.
- Byte lanes are little-endian:
  - byte k = bits [8k+7:8k], with k=addr[1:0];
  - half h = bits [16h+15:16h], with h=addr[1].
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
- Handshake:
  - A request is accepted on a posedge with req_valid=1 and state=IDLE.
  - addr, size, signed, write and wdata are latched at acceptance.
  - Requests presented while busy are ignored; the CPU holds them until req_ready=1.
- FSM states: IDLE, RD, RMW_RD, WR, ERR, RSP.
  - IDLE: on accept, go to ERR if misaligned (macro on); else RD for a load, WR for a word store, RMW_RD for a byte/half store.
  - RD: mem_read=1; extract and extend lanes from mem_rdata into the response register; go to RSP.
  - RMW_RD: mem_read=1; merge the store lane(s) of wdata into mem_rdata and store the result in the merge register; go to WR.
  - WR: mem_write=1 for exactly one full cycle (covers the memory's negedge write); mem_wdata = merge register, or latched wdata for a word store; go to RSP.
  - ERR: no memory strobes; set the misalign flag; go to RSP.
  - RSP: rsp_valid=1 for one cycle; go to IDLE. req_ready is 0 in RSP, so a new request is accepted at the earliest on the edge leaving RSP+1.
- Latency in clock edges after the accept edge:
  - load: 2 (rsp_valid high in cycle 2);
  - word store: 2;
  - sub-word store: 3;
  - misaligned: 2.
  - Throughput: one access per 3 cycles (4 for sub-word stores).
- mem_address is held at the latched word address in all non-IDLE states and is 0 in IDLE.
- Reset mid-operation:
  - Asserted in RMW_RD, or in WR before the falling edge: the write is aborted and memory is unchanged.
  - Asserted after the WR falling edge: the write has landed. No response is issued in either case.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned requests take the ERR path with rsp_misalign=1 and never touch memory.
- Undefined:
  - The ERR state is not built and rsp_misalign is tied to 0.
  - Low address bits are force-aligned (half: addr[0] cleared; word: addr[1:0] cleared).
  - The access proceeds normally.

Test Plan:
- Word round trip: memory all 0; sw 0x010 data 0xDEADBEEF -> mem_write high exactly one cycle at mem_address 0x010, rsp_valid 2 edges after accept; then lw 0x010 -> rsp_rdata=0xDEADBEEF.
- Byte store/load: word 0x010 = 0x11223344; sb 0x011 data 0x000000AA -> word becomes 0x1122AA44; lb 0x011 -> 0xFFFFFFAA; lbu 0x011 -> 0x000000AA.
- Halfword: word 0x010 = 0x11223344; sh 0x012 data 0x00008001 -> 0x80013344; lh 0x012 -> 0xFFFF8001; lhu 0x012 -> 0x00008001.
- Misaligned lw 0x013:
  - Macro on: rsp_valid with rsp_misalign=1, rsp_rdata=0, mem_read/mem_write never asserted.
  - Macro off: returns word 0x010 with rsp_misalign=0.
- Reset during RMW_RD of sb 0x011: resetn low for 1 cycle -> mem_write never pulses, word 0x010 unchanged, no rsp_valid, req_ready=1 after release.
- Busy hold: two back-to-back lw requests with req_valid held -> req_ready=0 during RD/RSP, the second request is accepted on the first edge with state=IDLE, each response occurs exactly once in order.
